// File: rtl/down_counter_3bit.sv
// Synchronous WIDTH-bit binary down counter with parallel load, zero flag and
// borrow output for cascading into wider countdown chains.
module down_counter_3bit #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             borrow_out
);

  logic [WIDTH-1:0] lower_zero;
  logic [WIDTH-1:0] dec_q;
  logic [WIDTH-1:0] next_q;

  // Borrow chain: bit i toggles when every lower bit is already zero.
  always_comb begin
    lower_zero    = '0;
    lower_zero[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      lower_zero[i] = lower_zero[i-1] & ~Q[i-1];
    end
    dec_q = Q ^ lower_zero;
  end

  // Priority below reset: load > en > hold.
  always_comb begin
    next_q = Q;
    if (load) begin
      next_q = load_val;
    end else if (en) begin
      next_q = dec_q;
    end
  end

  // Zero flag is registered alongside Q so it tracks Q with no added latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q    <= '0;
      zero <= 1'b1;
    end else begin
      Q    <= next_q;
      zero <= (next_q == '0);
    end
  end

  assign borrow_out = en & zero;

endmodule

// File: tb/tb_down_counter_3bit.sv
// Scoreboard bench for down_counter_3bit: single stage, two-stage cascade,
// and WIDTH=1 / WIDTH=8 instances, each checked against a modulo reference.
module tb_down_counter_3bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main 3-bit instance
  logic       reset = 1'b1, en = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] q;
  logic       zero, borrow;

  // Cascade: low stage borrow drives high stage enable
  logic       c_reset = 1'b1, c_en = 1'b0;
  logic [2:0] c_lo_q, c_hi_q;
  logic       c_lo_zero, c_hi_zero, c_lo_borrow, c_hi_borrow;

  // Width sweep instances
  logic       s_reset = 1'b1, s_en = 1'b0;
  logic [0:0] w1_q;
  logic [7:0] w8_q;
  logic       w1_zero, w1_borrow, w8_zero, w8_borrow;

  down_counter_3bit #(.WIDTH(3)) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .Q(q), .zero(zero), .borrow_out(borrow)
  );

  down_counter_3bit #(.WIDTH(3)) u_lo (
    .clk(clk), .reset(c_reset), .en(c_en), .load(1'b0), .load_val(3'd0),
    .Q(c_lo_q), .zero(c_lo_zero), .borrow_out(c_lo_borrow)
  );

  down_counter_3bit #(.WIDTH(3)) u_hi (
    .clk(clk), .reset(c_reset), .en(c_lo_borrow), .load(1'b0), .load_val(3'd0),
    .Q(c_hi_q), .zero(c_hi_zero), .borrow_out(c_hi_borrow)
  );

  down_counter_3bit #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(s_reset), .en(s_en), .load(1'b0), .load_val(1'b0),
    .Q(w1_q), .zero(w1_zero), .borrow_out(w1_borrow)
  );

  down_counter_3bit #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(s_reset), .en(s_en), .load(1'b0), .load_val(8'd0),
    .Q(w8_q), .zero(w8_zero), .borrow_out(w8_borrow)
  );

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  int unsigned m_q;
  bit          m_valid = 1'b0;
  int unsigned m_c;
  int unsigned m_w1;
  int unsigned m_w8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(q);
      1:       return 32'(zero);
      2:       return 32'({c_hi_q, c_lo_q});
      3:       return 32'(w1_q);
      4:       return 32'(w8_q);
      5:       return 32'(w8_zero);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input int sel, input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Advance one clock and retire everything the scoreboard expects after it.
  task automatic tick();
    sb_entry_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // One cycle on the main instance: drive, check borrow, predict, retire.
  task automatic cyc(input string tag, input logic r, input logic e,
                     input logic l, input logic [2:0] lv);
    reset    = r;
    en       = e;
    load     = l;
    load_val = lv;
    #1;
    if (m_valid) check({tag, "_borrow"}, 32'(borrow), 32'(e && (m_q == 0)));
    if (r)      m_q = 0;
    else if (l) m_q = lv;
    else if (e) m_q = (m_q + 7) % 8;
    m_valid = 1'b1;
    push(0, {tag, "_q"}, 32'(m_q));
    push(1, {tag, "_zero"}, 32'(m_q == 0));
    tick();
  endtask

  initial begin
    // Reset then count through a full wrap
    cyc("reset", 1'b1, 1'b0, 1'b0, 3'd0);
    cyc("reset", 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) cyc("count", 1'b0, 1'b1, 1'b0, 3'd0);
    check("count_end_q", 32'(q), 32'd7);

    // Parallel load, then load competing with en
    cyc("load5", 1'b0, 1'b0, 1'b1, 3'd5);
    for (int i = 0; i < 3; i++) cyc("after_load", 1'b0, 1'b1, 1'b0, 3'd0);
    cyc("load_en", 1'b0, 1'b1, 1'b1, 3'd6);
    check("load_wins_q", 32'(q), 32'd6);

    // Hold at 3 with en low
    cyc("load3", 1'b0, 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 4; i++) cyc("hold", 1'b0, 1'b0, 1'b0, 3'd7);
    cyc("hold_dec", 1'b0, 1'b1, 1'b0, 3'd0);

    // Reset mid-count overrides a simultaneous load
    cyc("load6", 1'b0, 1'b0, 1'b1, 3'd6);
    cyc("dec", 1'b0, 1'b1, 1'b0, 3'd0);
    cyc("dec", 1'b0, 1'b1, 1'b0, 3'd0);
    cyc("rst_load", 1'b1, 1'b1, 1'b1, 3'd2);
    check("rst_mid_q", 32'(q), 32'd0);
    cyc("rst_resume", 1'b0, 1'b1, 1'b0, 3'd0);
    check("resume_q", 32'(q), 32'd7);

    // Load of 0 with en high, then wrap with borrow
    cyc("load0_en", 1'b0, 1'b1, 1'b1, 3'd0);
    cyc("wrap", 1'b0, 1'b1, 1'b0, 3'd0);
    cyc("after_wrap", 1'b0, 1'b1, 1'b0, 3'd0);

    // Random mix of controls
    for (int i = 0; i < 60; i++) begin
      cyc("rand", 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
    end

    // Two-stage cascade counts down as one 6-bit value
    c_reset = 1'b1;
    c_en    = 1'b0;
    tick();
    tick();
    m_c = 0;
    check("casc_reset", observe(2), 32'd0);
    for (int i = 0; i < 64; i++) begin
      c_reset = 1'b0;
      c_en    = 1'b1;
      #1;
      check("casc_lo_borrow", 32'(c_lo_borrow), 32'((m_c % 8) == 0));
      m_c = (m_c + 63) % 64;
      push(2, "casc_q", 32'(m_c));
      tick();
    end
    check("casc_end", observe(2), 32'd0);

    // WIDTH=1 and WIDTH=8 sweep run side by side
    s_reset = 1'b1;
    s_en    = 1'b0;
    tick();
    tick();
    m_w1 = 0;
    m_w8 = 0;
    check("w1_reset", observe(3), 32'd0);
    check("w8_reset", observe(4), 32'd0);
    for (int i = 0; i < 257; i++) begin
      s_reset = 1'b0;
      s_en    = 1'b1;
      #1;
      if (i < 3) check("w1_borrow", 32'(w1_borrow), 32'(m_w1 == 0));
      check("w8_borrow", 32'(w8_borrow), 32'(m_w8 == 0));
      m_w1 = (m_w1 + 1) % 2;
      m_w8 = (m_w8 + 255) % 256;
      if (i < 3) push(3, "w1_q", 32'(m_w1));
      push(4, "w8_q", 32'(m_w8));
      push(5, "w8_zero", 32'(m_w8 == 0));
      tick();
    end
    check("w8_end", observe(4), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
